ps2_key_event_ctrl: RTL

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_event_fifo.sv | 66 ++++++
 rtl/ps2_key_event_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } dec_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard-to-host status bytes that never form part of a key event.
  localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
  localparam logic [7:0] PS2_IGN_BAT    = 8'hAA;
  localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
  localparam logic [7:0] PS2_IGN_BATF0  = 8'hFC;
  localparam logic [7:0] PS2_IGN_BATF1  = 8'hFD;
  localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
  localparam logic [7:0] PS2_IGN_ERR1   = 8'hFF;

  localparam logic [2:0] PauseSkip = 3'd7;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_IGN_ERR0)  || (b == PS2_IGN_BAT)   || (b == PS2_IGN_ECHO)   ||
           (b == PS2_IGN_ACK)   || (b == PS2_IGN_BATF0) || (b == PS2_IGN_BATF1)  ||
           (b == PS2_IGN_RESEND)|| (b == PS2_IGN_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Key event FIFO; a push into a full FIFO succeeds only if a pop frees a slot that cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t head,
  output logic       empty,
  output logic       dropped
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  ps2_event_t mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            pop_ok;
  logic            push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dropped = push & full & ~pop_ok;
  assign head    = mem[rd_ptr_q];

  // Depth is a power of two, so pointer increments wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code decoder feeding a key event FIFO with a sticky overflow flag.
// Optional PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of the currently held key.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scanCode,
  input  logic       scanCodeReady,
  input  logic       eventRead,
  input  logic       clearOverflow,
  output logic       eventValid,
  output logic [7:0] eventCode,
  output logic       eventExtended,
  output logic       eventRelease,
  output logic       overflow
);

  dec_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       dec_push;
  ps2_event_t dec_evt;
  logic       fifo_push;
  ps2_event_t head;
  logic       fifo_empty;
  logic       fifo_dropped;
  logic       overflow_q, overflow_d;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    dec_push = 1'b0;
    dec_evt  = '{code: scanCode, ext: 1'b0, rel: 1'b0};
    if (scanCodeReady) begin
      unique case (state_q)
        StIdle: begin
          if (scanCode == PS2_EXT) begin
            state_d = StExt;
          end else if (scanCode == PS2_BRK) begin
            state_d = StBrk;
          end else if (scanCode == PS2_PAUSE) begin
            state_d = StPause;
            skip_d  = PauseSkip;
          end else if (!is_ignored(scanCode)) begin
            dec_push = 1'b1;
          end
        end
        StExt: begin
          if (scanCode == PS2_BRK) begin
            state_d = StExtBrk;
          end else if (scanCode != PS2_EXT) begin
            dec_push    = 1'b1;
            dec_evt.ext = 1'b1;
            state_d     = StIdle;
          end
        end
        StBrk: begin
          state_d     = StIdle;
          dec_push    = (scanCode != PS2_EXT) && (scanCode != PS2_BRK);
          dec_evt.rel = 1'b1;
        end
        StExtBrk: begin
          state_d     = StIdle;
          dec_push    = (scanCode != PS2_EXT) && (scanCode != PS2_BRK);
          dec_evt.ext = 1'b1;
          dec_evt.rel = 1'b1;
        end
        StPause: begin
          // The last of the seven trailing bytes emits the single Pause event.
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d   = 3'd0;
            state_d  = StIdle;
            dec_push = 1'b1;
            dec_evt  = '{code: PS2_PAUSE, ext: 1'b1, rel: 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      skip_q     <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_q, held_valid_d;
  logic [8:0] held_key_q, held_key_d;
  logic       key_match;
  logic       repeat_hit;

  assign key_match  = held_valid_q && (held_key_q == {dec_evt.code, dec_evt.ext});
  assign repeat_hit = dec_push && !dec_evt.rel && key_match;
  assign fifo_push  = dec_push && !repeat_hit;

  always_comb begin
    held_valid_d = held_valid_q;
    held_key_d   = held_key_q;
    if (dec_push) begin
      if (!dec_evt.rel) begin
        if (!key_match) begin
          held_valid_d = 1'b1;
          held_key_d   = {dec_evt.code, dec_evt.ext};
        end
      end else if (key_match) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_valid_q <= 1'b0;
      held_key_q   <= 9'd0;
    end else begin
      held_valid_q <= held_valid_d;
      held_key_q   <= held_key_d;
    end
  end
`else
  assign fifo_push = dec_push;
`endif

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(dec_evt),
    .pop      (eventRead),
    .head     (head),
    .empty    (fifo_empty),
    .dropped  (fifo_dropped)
  );

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  assign overflow_d = (overflow_q & ~clearOverflow) | fifo_dropped;

  assign eventValid    = ~fifo_empty;
  assign eventCode     = fifo_empty ? 8'h00 : head.code;
  assign eventExtended = fifo_empty ? 1'b0  : head.ext;
  assign eventRelease  = fifo_empty ? 1'b0  : head.rel;
  assign overflow      = overflow_q;

endmodule
